// File: rtl/fetch_aligner_pkg.sv
// Shared definitions for the instruction-fetch aligner: FSM states,
// queue depth and the opcode pattern that marks a 32-bit instruction.
package fetch_aligner_pkg;

  localparam int QDEPTH = 4;
  localparam logic [1:0] OPC_MASK_UNCOMP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  function automatic logic is_uncompressed(input logic [15:0] hw);
    return hw[1:0] == OPC_MASK_UNCOMP;
  endfunction

endpackage

// File: rtl/fetch_aligner_if.sv
// Bus bundle between the fetch aligner, instruction memory, the redirect
// source and the decompressor. master = aligner side, slave = environment.
interface fetch_aligner_if #(parameter int ADDR_W = 8);

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;

  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_compressed;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_req_addr,
    output instr_valid, instr_data, instr_pc, instr_compressed
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_req_addr,
    input  instr_valid, instr_data, instr_pc, instr_compressed
  );

endinterface

// File: rtl/fetch_aligner_halfword_queue.sv
// Four-entry halfword FIFO that also tracks the PC of its head entry.
// Pushes and pops of one or two halfwords may happen in the same cycle.
module halfword_queue
  import fetch_aligner_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic [1:0]        push_num,
  input  logic [15:0]       push_hw0,
  input  logic [15:0]       push_hw1,
  input  logic [1:0]        pop_num,
  output logic [2:0]        count,
  output logic [15:0]       head_hw0,
  output logic [15:0]       head_hw1,
  output logic [ADDR_W-1:0] head_pc
);

  localparam int PTR_W = $clog2(QDEPTH);

  logic [15:0]       mem_q [QDEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [2:0]        count_q;
  logic [ADDR_W-1:0] head_pc_q;

  // Flush wins over any push or pop requested in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      head_pc_q <= RESET_PC;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      head_pc_q <= flush_pc;
    end else begin
      if (push_num != 2'd0) mem_q[tail_q] <= push_hw0;
      if (push_num == 2'd2) mem_q[tail_q + PTR_W'(1)] <= push_hw1;
      tail_q    <= tail_q + PTR_W'(push_num);
      head_q    <= head_q + PTR_W'(pop_num);
      count_q   <= count_q + {1'b0, push_num} - {1'b0, pop_num};
      head_pc_q <= head_pc_q + ADDR_W'({pop_num, 1'b0});
    end
  end

  assign count    = count_q;
  assign head_hw0 = mem_q[head_q];
  assign head_hw1 = mem_q[head_q + PTR_W'(1)];
  assign head_pc  = head_pc_q;

endmodule

// File: rtl/fetch_aligner.sv
// RV32IMC fetch front end: fetches aligned words, queues halfwords and hands
// exactly one whole (16- or 32-bit) instruction with its PC per handshake.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  fetch_aligner_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              skip_lo_q, skip_lo_d;
  logic              drop_q, drop_d;

  logic [2:0]        count;
  logic [15:0]       head_hw0, head_hw1;
  logic [ADDR_W-1:0] head_pc;
  logic              head_uncomp;
  logic              instr_valid;
  logic              rsp_take;
  logic              push;
  logic [1:0]        push_num;
  logic [1:0]        pop_num;
  logic [2:0]        count_left;
  logic [2:0]        count_after;

  halfword_queue #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect_valid),
    .flush_pc (bus.redirect_pc & ~ADDR_W'(1)),
    .push_num (push_num),
    .push_hw0 (skip_lo_q ? bus.imem_rsp_data[31:16] : bus.imem_rsp_data[15:0]),
    .push_hw1 (bus.imem_rsp_data[31:16]),
    .pop_num  (pop_num),
    .count    (count),
    .head_hw0 (head_hw0),
    .head_hw1 (head_hw1),
    .head_pc  (head_pc)
  );

  // A 32-bit head waits until its second halfword is queued.
  assign head_uncomp = is_uncompressed(head_hw0);
  assign instr_valid = (count >= 3'd1 && !head_uncomp) || (count >= 3'd2 && head_uncomp);

  assign pop_num  = (instr_valid && bus.instr_ready && !bus.redirect_valid)
                    ? (head_uncomp ? 2'd2 : 2'd1) : 2'd0;
  assign rsp_take = (state_q == WAIT) && bus.imem_rsp_valid;
  assign push     = rsp_take && !drop_q && !bus.redirect_valid;
  assign push_num = push ? (skip_lo_q ? 2'd1 : 2'd2) : 2'd0;

  assign count_left  = count - {1'b0, pop_num};
  assign count_after = count_left + {1'b0, push_num};

  assign bus.instr_valid      = instr_valid;
  assign bus.instr_data       = !instr_valid ? 32'h0
                              : (head_uncomp ? {head_hw1, head_hw0} : {16'h0, head_hw0});
  assign bus.instr_pc         = instr_valid ? head_pc : '0;
  assign bus.instr_compressed = instr_valid && !head_uncomp;
  assign bus.imem_req_valid   = (state_q == REQ);
  assign bus.imem_req_addr    = (state_q == REQ) ? fetch_addr_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC & ~ADDR_W'(3);
      skip_lo_q    <= RESET_PC[1];
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      skip_lo_q    <= skip_lo_d;
      drop_q       <= drop_d;
    end
  end

  // One request in flight at most; a redirect retargets fetch and marks any
  // already-accepted request so its response is thrown away.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    skip_lo_d    = skip_lo_q;
    drop_d       = drop_q;

    if (push) skip_lo_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.redirect_valid || count_left <= 3'd2) state_d = REQ;
      end
      REQ: begin
        if (bus.imem_req_ready) begin
          state_d      = WAIT;
          fetch_addr_d = fetch_addr_q + ADDR_W'(4);
          if (bus.redirect_valid) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          drop_d = 1'b0;
          if (bus.redirect_valid || count_after <= 3'd2) state_d = REQ;
          else                                          state_d = IDLE;
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.redirect_valid) begin
      fetch_addr_d = bus.redirect_pc & ~ADDR_W'(3);
      skip_lo_d    = bus.redirect_pc[1];
    end
  end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction-fetch front end for the RV32IMC pipeline; the producer side of the decompressor's instruction interface.
- Fetches word-aligned 32-bit words from instruction memory and splits them into a halfword queue.
- Delivers exactly one whole instruction per handshake, with its PC, to the decompressor: a 16-bit instruction in bits [15:0], or a 32-bit instruction even when it straddles two words.
- Downstream never needs a halfword step signal or PC-parity logic.

Parameters:
ADDR_W, 8, byte-address width of PC and instruction memory
RESET_PC, 0, first fetch PC after reset (halfword aligned)
QDEPTH, 4, halfword queue depth (fixed at 4; a power of two is required)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  flush and restart fetch (branch/jump/trap)
redirect_pc  in  ADDR_W  new PC; bit0 ignored
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  ADDR_W  word address, bits [1:0] always 0
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  read data valid; arrives at least 1 cycle after acceptance
imem_rsp_data  in  32  little-endian fetched word
instr_valid  out  1  instr_data holds a complete instruction
instr_ready  in  1  pipeline accepts the instruction (low = stall)
instr_data  out  32  {16'h0, hw} if compressed, else {hw1, hw0}
instr_pc  out  ADDR_W  PC of instr_data
instr_compressed  out  1  1 when instr_data[1:0] != 2'b11

Behaviour:
- Reset (async, rst_n=0):
  - Queue empty, drop=0, FSM=IDLE.
  - fetch_addr = RESET_PC & ~3; skip_lo = RESET_PC[1]; head_pc = RESET_PC.
  - All outputs 0.
- Queue: 4 halfword entries, head/tail pointers, 3-bit count. Entry i's PC is head_pc + 2i.
- Push:
  - An accepted response pushes hw[15:0] then hw[31:16].
  - If skip_lo=1, only the upper halfword is pushed, then skip_lo clears.
- Output, combinational from registers only:
  - instr_valid = (count>=1 && head[1:0]!=2'b11) || (count>=2 && head[1:0]==2'b11).
  - A 32-bit instruction with only one halfword present waits; it is not an error.
  - Outputs stay stable while instr_valid && !instr_ready: pushes only touch the tail.
- Pop on instr_valid && instr_ready: remove 1 (compressed) or 2 halfwords; head_pc += 2 or 4, wrapping mod 2^ADDR_W.
- Same-cycle push and pop are both applied; count = count + pushed - popped.
- Fetch FSM, one outstanding request max:
  - IDLE: go to REQ when (count - popping_now) <= 2, i.e. room for a full word.
  - REQ: imem_req_valid=1, imem_req_addr=fetch_addr. On imem_req_ready: fetch_addr += 4 (wraps), go to WAIT.
  - WAIT: on imem_rsp_valid, push unless drop=1, clear drop. Go to REQ if space remains after the push, else IDLE.
- Redirect (highest priority over push/pop that cycle):
  - Queue flushed, count=0.
  - head_pc = redirect_pc & ~1; fetch_addr = redirect_pc & ~3; skip_lo = redirect_pc[1].
  - instr_valid is 0 in the following cycle.
  - In WAIT (including a same-cycle response): that response is discarded. drop=1 if the response is not in this cycle; FSM continues to WAIT, then REQ.
  - In REQ with imem_req_ready=1 the same cycle: the old-address request counts as accepted. Set drop=1, go to WAIT, fetch_addr = new address.
  - In REQ without ready: stay in REQ with the new address. The request is simply retargeted.
  - In IDLE: go to REQ.
- imem_req_valid stays asserted until ready; imem_req_addr does not change while in REQ except by redirect.
- Memory errors are not modelled.

Decomposition:
- Shared package/header: FSM state encodings (IDLE/REQ/WAIT), the OPC_MASK_UNCOMP constant 2'b11, and QDEPTH.
- One natural sub-module, halfword_queue: 4x16 storage, push 1–2, pop 1–2, count, head_pc tracking.
- The FSM and redirect logic stay in fetch_aligner.

Test Plan:
- All-compressed stream: reset with RESET_PC=0, memory word 0 = 32'h4505_4485 → instr 32'h0000_4485 @pc 0, then 32'h0000_4505 @pc 2; each one cycle when instr_ready=1.
- Straddling 32-bit instruction: word0 = {16'h0513, 16'h4485}, word1 = {16'h4505, 16'h0000} → 16'h4485 @0, 32'h0000_0513 @2 (compressed=0), 16'h4505 @6.
- Stall/backpressure: hold instr_ready=0 for 10 cycles with 3-cycle memory latency → instr_data/instr_pc stable, imem_req_valid drops once count would exceed 2, no queue overflow.
- Redirect to odd halfword: redirect_pc=8'h0A while a request is in WAIT → stale response dropped, next request addr 8'h08, first instr_pc 8'h0A taken from the upper halfword.
- Redirect same cycle as imem_rsp_valid, and same cycle as imem_req_ready in REQ → neither old word ever appears on instr_data; next delivered instr_pc equals redirect_pc.
- Async reset mid-WAIT: assert rst_n=0 with a response pending → outputs 0 immediately; after release, first request addr = RESET_PC & ~3; a late stray response is ignored (FSM is IDLE).
